// File: rtl/tl_mem_arbiter.sv
// tl_mem_arbiter: round-robin TileLink-UL A-channel arbiter onto a single memory port,
// with port-prefixed source IDs, D-channel routing by prefix and per-port outstanding limits.
module tl_mem_arbiter #(
    parameter int PORTS   = 4,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int SRC_W   = 2,
    parameter int MAX_OUT = 4,
    localparam int IDX_W  = $clog2(PORTS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [PORTS*3-1:0]       up_a_opcode_i,
    input  logic [PORTS*3-1:0]       up_a_param_i,
    input  logic [PORTS*3-1:0]       up_a_size_i,
    input  logic [PORTS*SRC_W-1:0]   up_a_source_i,
    input  logic [PORTS*ADDR_W-1:0]  up_a_address_i,
    input  logic [PORTS*8-1:0]       up_a_mask_i,
    input  logic [PORTS*DATA_W-1:0]  up_a_data_i,
    input  logic [PORTS-1:0]         up_a_valid_i,
    output logic [PORTS-1:0]         up_a_ready_o,
    output logic [2:0]               up_d_opcode_o,
    output logic [2:0]               up_d_size_o,
    output logic [1:0]               up_d_param_o,
    output logic [1:0]               up_d_sink_o,
    output logic                     up_d_denied_o,
    output logic                     up_d_corrupt_o,
    output logic [DATA_W-1:0]        up_d_data_o,
    output logic [SRC_W-1:0]         up_d_source_o,
    output logic [PORTS-1:0]         up_d_valid_o,
    input  logic [PORTS-1:0]         up_d_ready_i,
    output logic [2:0]               mem_a_opcode_o,
    output logic [2:0]               mem_a_param_o,
    output logic [2:0]               mem_a_size_o,
    output logic [SRC_W+IDX_W-1:0]   mem_a_source_o,
    output logic [ADDR_W-1:0]        mem_a_address_o,
    output logic [7:0]               mem_a_mask_o,
    output logic [DATA_W-1:0]        mem_a_data_o,
    output logic                     mem_a_valid_o,
    input  logic                     mem_a_ready_i,
    input  logic [2:0]               mem_d_opcode_i,
    input  logic [1:0]               mem_d_param_i,
    input  logic [2:0]               mem_d_size_i,
    input  logic [SRC_W+IDX_W-1:0]   mem_d_source_i,
    input  logic [1:0]               mem_d_sink_i,
    input  logic                     mem_d_denied_i,
    input  logic [DATA_W-1:0]        mem_d_data_i,
    input  logic                     mem_d_corrupt_i,
    input  logic                     mem_d_valid_i,
    output logic                     mem_d_ready_o
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [0:0] IDLE = 1'b0, ACTIVE = 1'b1;

    logic [0:0]        state;
    logic [IDX_W-1:0]  grant_idx, rr_ptr, pick, idx, d_port;
    logic [3:0]        beat_cnt, d_beat_cnt;
    logic              first_beat, found, a_fire, d_fire, d_last;
    logic [CNT_W-1:0]  out_cnt [PORTS];
    logic [2:0]        a_op [PORTS], a_param [PORTS], a_size [PORTS];
    logic [SRC_W-1:0]  a_src [PORTS];
    logic [ADDR_W-1:0] a_addr [PORTS];
    logic [7:0]        a_mask [PORTS];
    logic [DATA_W-1:0] a_data [PORTS];
    logic [3:0]        a_last [PORTS];
    logic [PORTS-1:0]  elig, inc, dec;

    // index of the final beat of a burst message of the given size
    function automatic logic [3:0] last_beat(input logic [2:0] size);
        logic [4:0] n;
        n = 5'd1 << (size - 3'd3);
        return (size > 3'd3) ? 4'(n - 5'd1) : 4'd0;
    endfunction

    for (genvar g = 0; g < PORTS; g++) begin : g_port
        assign a_op[g]    = up_a_opcode_i[g*3 +: 3];
        assign a_param[g] = up_a_param_i[g*3 +: 3];
        assign a_size[g]  = up_a_size_i[g*3 +: 3];
        assign a_src[g]   = up_a_source_i[g*SRC_W +: SRC_W];
        assign a_addr[g]  = up_a_address_i[g*ADDR_W +: ADDR_W];
        assign a_mask[g]  = up_a_mask_i[g*8 +: 8];
        assign a_data[g]  = up_a_data_i[g*DATA_W +: DATA_W];
        assign a_last[g]  = (a_op[g] == 3'd0 || a_op[g] == 3'd1) ? last_beat(a_size[g]) : 4'd0;
        assign elig[g]    = up_a_valid_i[g] && (out_cnt[g] < CNT_W'(MAX_OUT));
        assign inc[g]     = a_fire && first_beat && (grant_idx == IDX_W'(g));
        assign dec[g]     = d_last && (d_port == IDX_W'(g));
    end

    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        idx   = rr_ptr;
        for (int i = 0; i < PORTS; i++) begin
            idx = rr_ptr + IDX_W'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign mem_a_valid_o   = (state == ACTIVE) && up_a_valid_i[grant_idx];
    assign a_fire          = mem_a_valid_o && mem_a_ready_i;
    assign up_a_ready_o    = (state == ACTIVE && mem_a_ready_i) ? PORTS'(1) << grant_idx : '0;
    assign mem_a_opcode_o  = a_op[grant_idx];
    assign mem_a_param_o   = a_param[grant_idx];
    assign mem_a_size_o    = a_size[grant_idx];
    assign mem_a_source_o  = {grant_idx, a_src[grant_idx]};
    assign mem_a_address_o = a_addr[grant_idx];
    assign mem_a_mask_o    = a_mask[grant_idx];
    assign mem_a_data_o    = a_data[grant_idx];

    // D routing is combinational but still forced quiet while reset is asserted
    assign d_port         = mem_d_source_i[SRC_W +: IDX_W];
    assign mem_d_ready_o  = rst_ni && up_d_ready_i[d_port];
    assign up_d_valid_o   = (rst_ni && mem_d_valid_i) ? PORTS'(1) << d_port : '0;
    assign d_fire         = mem_d_valid_i && mem_d_ready_o;
    assign d_last         = d_fire && (d_beat_cnt == ((mem_d_opcode_i == 3'd1) ? last_beat(mem_d_size_i) : 4'd0));
    assign up_d_opcode_o  = mem_d_opcode_i;
    assign up_d_size_o    = mem_d_size_i;
    assign up_d_param_o   = mem_d_param_i;
    assign up_d_sink_o    = mem_d_sink_i;
    assign up_d_denied_o  = mem_d_denied_i;
    assign up_d_corrupt_o = mem_d_corrupt_i;
    assign up_d_data_o    = mem_d_data_i;
    assign up_d_source_o  = mem_d_source_i[SRC_W-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            grant_idx  <= '0;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
            first_beat <= 1'b0;
            d_beat_cnt <= '0;
            for (int p = 0; p < PORTS; p++) out_cnt[p] <= '0;
        end else begin
            if (state == IDLE) begin
                if (found) begin
                    state      <= ACTIVE;
                    grant_idx  <= pick;
                    beat_cnt   <= a_last[pick];
                    first_beat <= 1'b1;
                end
            end else if (a_fire) begin
                first_beat <= 1'b0;
                if (beat_cnt == 4'd0) begin
                    state  <= IDLE;
                    rr_ptr <= grant_idx + 1'b1;
                end else begin
                    beat_cnt <= beat_cnt - 4'd1;
                end
            end
            if (d_fire) d_beat_cnt <= d_last ? 4'd0 : d_beat_cnt + 4'd1;
            for (int p = 0; p < PORTS; p++) begin
                if (inc[p] && !dec[p] && out_cnt[p] < CNT_W'(MAX_OUT)) out_cnt[p] <= out_cnt[p] + 1'b1;
                else if (dec[p] && !inc[p] && out_cnt[p] != '0) out_cnt[p] <= out_cnt[p] - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tl_mem_arbiter.sv
// tb_tl_mem_arbiter: directed scenarios against a message-level model of arbitration,
// outstanding limits and D routing, plus literal expectations per scenario.
module tb_tl_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [11:0]  a_opcode = '0, a_param = '0, a_size = '0;
    logic [7:0]   a_source = '0;
    logic [255:0] a_address = '0, a_data = '0;
    logic [31:0]  a_mask = '0;
    logic [3:0]   a_valid = '0, a_ready;
    logic [2:0]   ud_opcode, ud_size;
    logic [1:0]   ud_param, ud_sink, ud_source;
    logic         ud_denied, ud_corrupt;
    logic [63:0]  ud_data;
    logic [3:0]   ud_valid, ud_ready = 4'hF;
    logic [2:0]   ma_opcode, ma_param, ma_size;
    logic [3:0]   ma_source;
    logic [63:0]  ma_address, ma_data;
    logic [7:0]   ma_mask;
    logic         ma_valid, ma_ready = 1'b1;
    logic [2:0]   md_opcode = '0, md_size = '0;
    logic [1:0]   md_param = '0, md_sink = '0;
    logic [3:0]   md_source = '0;
    logic         md_denied = 1'b0, md_corrupt = 1'b0, md_valid = 1'b0, md_ready;
    logic [63:0]  md_data = '0;

    tl_mem_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .up_a_opcode_i(a_opcode), .up_a_param_i(a_param), .up_a_size_i(a_size),
        .up_a_source_i(a_source), .up_a_address_i(a_address), .up_a_mask_i(a_mask),
        .up_a_data_i(a_data), .up_a_valid_i(a_valid), .up_a_ready_o(a_ready),
        .up_d_opcode_o(ud_opcode), .up_d_size_o(ud_size), .up_d_param_o(ud_param),
        .up_d_sink_o(ud_sink), .up_d_denied_o(ud_denied), .up_d_corrupt_o(ud_corrupt),
        .up_d_data_o(ud_data), .up_d_source_o(ud_source), .up_d_valid_o(ud_valid),
        .up_d_ready_i(ud_ready),
        .mem_a_opcode_o(ma_opcode), .mem_a_param_o(ma_param), .mem_a_size_o(ma_size),
        .mem_a_source_o(ma_source), .mem_a_address_o(ma_address), .mem_a_mask_o(ma_mask),
        .mem_a_data_o(ma_data), .mem_a_valid_o(ma_valid), .mem_a_ready_i(ma_ready),
        .mem_d_opcode_i(md_opcode), .mem_d_param_i(md_param), .mem_d_size_i(md_size),
        .mem_d_source_i(md_source), .mem_d_sink_i(md_sink), .mem_d_denied_i(md_denied),
        .mem_d_data_i(md_data), .mem_d_corrupt_i(md_corrupt), .mem_d_valid_i(md_valid),
        .mem_d_ready_o(md_ready)
    );

    typedef struct {logic [2:0] op; logic [2:0] size; logic [1:0] src;} msg_t;
    typedef struct {logic [3:0] src; logic [63:0] data; longint cyc;} fire_t;
    msg_t   q [4][$];
    int     beat [4];
    fire_t  log_q [$];
    longint d_log [$];
    longint cyc = 0;
    int     checks = 0, failures = 0;

    int m_owner = -1, m_left = 0, m_rr = 0, m_dbeat = 0;
    int m_out [4] = '{default: 0};
    bit m_first = 1'b0;

    function automatic int nbeats(input logic [2:0] op, input logic [2:0] size);
        return (op <= 3'd1 && size > 3'd3) ? (1 << (size - 3)) : 1;
    endfunction

    function automatic int dbeats(input logic [2:0] op, input logic [2:0] size);
        return (op == 3'd1 && size > 3'd3) ? (1 << (size - 3)) : 1;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int p, input logic [2:0] op, input logic [2:0] size, input logic [1:0] src);
        msg_t m;
        m.op = op; m.size = size; m.src = src;
        q[p].push_back(m);
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (log_q.size() < n) begin
            failures++;
            $display("FAIL %s timeout: got %0d A beats expected %0d", name, log_q.size(), n);
        end
    endtask

    task automatic do_reset();
        md_valid = 1'b0;
        ma_ready = 1'b1;
        ud_ready = 4'hF;
        #2 rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        log_q.delete();
        d_log.delete();
    endtask

    task automatic send_d(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                          input int stall_at, input logic [3:0] exp_dv);
        int k;
        logic f;
        for (int b = 0; b < dbeats(op, size); b++) begin
            md_valid = 1'b1; md_opcode = op; md_size = size; md_source = src;
            md_data = 64'hD000 + 64'(b); md_param = 2'd0; md_sink = 2'd1;
            if (b == stall_at) begin
                ud_ready[src[3:2]] = 1'b0;
                @(negedge clk);
                check("d_stall_ready", 128'(md_ready), 128'd0);
                check("d_stall_valid", 128'(ud_valid), 128'(exp_dv));
                @(posedge clk);
                #1 ud_ready[src[3:2]] = 1'b1;
            end
            k = 0;
            f = 1'b0;
            while (!f && k < 50) begin
                @(negedge clk);
                f = md_ready;
                @(posedge clk);
                #1 k++;
            end
            if (!f) begin
                checks++;
                failures++;
                $display("FAIL d_beat timeout: beat %0d got no ready expected ready", b);
            end
        end
        md_valid = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // upstream masters: each port replays its queued messages beat by beat
    initial begin
        logic [3:0] fired;
        forever begin
            @(negedge clk);
            fired = a_valid & a_ready;
            @(posedge clk);
            #1;
            for (int p = 0; p < 4; p++) begin
                if (!rst_n) begin
                    q[p].delete();
                    beat[p] = 0;
                end else if (fired[p] && q[p].size() > 0) begin
                    beat[p]++;
                    if (beat[p] == nbeats(q[p][0].op, q[p][0].size)) begin
                        void'(q[p].pop_front());
                        beat[p] = 0;
                    end
                end
                if (q[p].size() > 0) begin
                    a_valid[p] = 1'b1;
                    a_opcode[p*3 +: 3] = q[p][0].op;
                    a_param[p*3 +: 3] = 3'd0;
                    a_size[p*3 +: 3] = q[p][0].size;
                    a_source[p*2 +: 2] = q[p][0].src;
                    a_mask[p*8 +: 8] = 8'hFF;
                    a_address[p*64 +: 64] = 64'h1000 * 64'(p + 1) + 64'(beat[p] * 8);
                    a_data[p*64 +: 64] = 64'hA5A5_0000 | (64'(p) << 8) | 64'(beat[p]);
                end else begin
                    a_valid[p] = 1'b0;
                end
            end
        end
    end

    // message-level reference: who owns the memory port and how many requests each port has in flight
    initial forever begin
        int dp;
        int inc_p, dec_p;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_owner = -1; m_left = 0; m_rr = 0; m_dbeat = 0; m_first = 1'b0;
            m_out = '{default: 0};
        end else begin
            inc_p = -1;
            dec_p = -1;
            if (m_owner < 0) begin
                for (int i = 0; i < 4; i++) begin
                    int p;
                    p = (m_rr + i) % 4;
                    if (m_owner < 0 && a_valid[p] && m_out[p] < 4) begin
                        m_owner = p;
                        m_left = nbeats(a_opcode[p*3 +: 3], a_size[p*3 +: 3]);
                        m_first = 1'b1;
                    end
                end
            end else if (a_valid[m_owner] && ma_ready) begin
                if (m_first) inc_p = m_owner;
                m_first = 1'b0;
                m_left--;
                if (m_left == 0) begin
                    m_rr = (m_owner + 1) % 4;
                    m_owner = -1;
                end
            end
            dp = int'(md_source[3:2]);
            if (md_valid && ud_ready[dp]) begin
                m_dbeat++;
                if (m_dbeat == dbeats(md_opcode, md_size)) begin
                    dec_p = dp;
                    m_dbeat = 0;
                end
            end
            if (inc_p >= 0 && inc_p != dec_p && m_out[inc_p] < 4) m_out[inc_p]++;
            if (dec_p >= 0 && dec_p != inc_p && m_out[dec_p] > 0) m_out[dec_p]--;
        end
    end

    initial forever begin
        logic exp_v;
        logic [3:0] exp_r;
        int o, dp;
        fire_t f;
        @(negedge clk);
        if (rst_n) begin
            o = m_owner;
            exp_v = (o >= 0) && a_valid[o];
            exp_r = (o >= 0 && ma_ready) ? (4'b1 << o) : 4'b0;
            check("a_valid", 128'(ma_valid), 128'(exp_v));
            check("a_ready", 128'(a_ready), 128'(exp_r));
            if (exp_v) begin
                check("a_source", 128'(ma_source), 128'({2'(o), a_source[o*2 +: 2]}));
                check("a_address", 128'(ma_address), 128'(a_address[o*64 +: 64]));
                check("a_data", 128'(ma_data), 128'(a_data[o*64 +: 64]));
                check("a_header", 128'({ma_opcode, ma_param, ma_size, ma_mask}),
                      128'({a_opcode[o*3 +: 3], a_param[o*3 +: 3], a_size[o*3 +: 3], a_mask[o*8 +: 8]}));
            end
            dp = int'(md_source[3:2]);
            check("d_valid", 128'(ud_valid), md_valid ? 128'(4'b1 << dp) : 128'd0);
            check("d_ready", 128'(md_ready), 128'(ud_ready[dp]));
            if (md_valid) begin
                check("d_fields", 128'({ud_source, ud_opcode, ud_size, ud_param, ud_sink, ud_denied, ud_corrupt}),
                      128'({md_source[1:0], md_opcode, md_size, md_param, md_sink, md_denied, md_corrupt}));
                check("d_data", 128'(ud_data), 128'(md_data));
            end
            if (ma_valid && ma_ready) begin
                f.src = ma_source; f.data = ma_data; f.cyc = cyc;
                log_q.push_back(f);
            end
            if (md_valid && md_ready) d_log.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        md_valid = 1'b1;
        md_source = 4'h8;
        #1;
        check("reset_outputs", 128'({ma_valid, a_ready, ud_valid, md_ready}), 128'd0);
        md_valid = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        push(0, 3'd4, 3'd6, 2'd1);
        push(2, 3'd4, 3'd6, 2'd3);
        wait_log(2, 20, "t1_gets");
        check("t1_first_src", 128'(log_q[0].src), 128'h1);
        check("t1_second_src", 128'(log_q[1].src), 128'hB);
        check("t1_bubble", 128'(log_q[1].cyc - log_q[0].cyc), 128'd2);
        push(0, 3'd4, 3'd6, 2'd2);
        push(3, 3'd4, 3'd6, 2'd0);
        wait_log(4, 20, "t1_rr");
        check("t1_rr_first", 128'(log_q[2].src), 128'hC);
        check("t1_rr_second", 128'(log_q[3].src), 128'h2);

        do_reset();
        push(1, 3'd0, 3'd6, 2'd2);
        push(3, 3'd4, 3'd6, 2'd1);
        n = 0;
        while (log_q.size() < 9 && n < 80) begin
            ma_ready = ~ma_ready;
            tick(1);
            n++;
        end
        ma_ready = 1'b1;
        wait_log(9, 10, "t2_put");
        n = 0;
        for (int i = 0; i < 8; i++) if (log_q[i].src == 4'h6) n++;
        check("t2_p1_beats", 128'(n), 128'd8);
        check("t2_last_data", 128'(log_q[7].data), 128'hA5A5_0107);
        check("t2_p3_after", 128'(log_q[8].src), 128'hD);

        do_reset();
        for (int s = 0; s < 4; s++) push(2, 3'd4, 3'd6, 2'(s));
        wait_log(4, 40, "t3_fill");
        push(2, 3'd4, 3'd6, 2'd0);
        tick(5);
        check("t3_blocked", 128'(log_q.size()), 128'd4);
        send_d(3'd1, 3'd6, 4'hA, 3, 4'b0100);
        check("t3_d_beats", 128'(d_log.size()), 128'd8);
        check("t3_held", 128'(log_q.size()), 128'd4);
        wait_log(5, 20, "t3_release");
        check("t3_order", 128'(log_q[4].cyc > d_log[d_log.size()-1]), 128'd1);

        do_reset();
        for (int i = 0; i < 5; i++) push(0, 3'd4, 3'd6, 2'(i % 4));
        push(1, 3'd4, 3'd6, 2'd0);
        push(1, 3'd4, 3'd6, 2'd1);
        wait_log(6, 60, "t4_mix");
        tick(6);
        check("t4_capped", 128'(log_q.size()), 128'd6);
        check("t4_order", 128'({log_q[0].src, log_q[1].src, log_q[2].src, log_q[3].src, log_q[4].src, log_q[5].src}),
              128'h041523);
        send_d(3'd0, 3'd3, 4'h0, -1, 4'b0001);
        wait_log(7, 20, "t4_reenable");
        check("t4_reenabled", 128'(log_q[6].src), 128'h0);

        do_reset();
        push(0, 3'd4, 3'd6, 2'd0);
        push(0, 3'd4, 3'd6, 2'd1);
        wait_log(2, 20, "t5_prime");
        ma_ready = 1'b0;
        push(0, 3'd4, 3'd6, 2'd2);
        tick(4);
        md_valid = 1'b1; md_opcode = 3'd0; md_size = 3'd3; md_source = 4'h0;
        ud_ready[0] = 1'b0;
        tick(2);
        ud_ready[0] = 1'b1;
        ma_ready = 1'b1;
        tick(1);
        md_valid = 1'b0;
        wait_log(3, 5, "t5_same_edge_fire");
        check("t5_same_edge", 128'(log_q[2].cyc == d_log[0]), 128'd1);
        push(0, 3'd4, 3'd6, 2'd3);
        push(0, 3'd4, 3'd6, 2'd0);
        push(0, 3'd4, 3'd6, 2'd1);
        wait_log(5, 40, "t5_more");
        tick(6);
        check("t5_count", 128'(log_q.size()), 128'd5);

        do_reset();
        push(1, 3'd0, 3'd6, 2'd1);
        wait_log(3, 20, "t6_burst");
        check("t6_pre", 128'({ma_valid, a_ready}), 128'({1'b1, 4'b0010}));
        md_valid = 1'b1;
        md_source = 4'h4;
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_flags", 128'({ma_valid, a_ready, ud_valid, md_ready}), 128'd0);
        md_valid = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        log_q.delete();
        d_log.delete();
        push(3, 3'd4, 3'd6, 2'd0);
        push(0, 3'd4, 3'd6, 2'd1);
        wait_log(2, 20, "t6_after");
        check("t6_rr_reset", 128'(log_q[0].src), 128'h1);
        check("t6_p3", 128'(log_q[1].src), 128'hC);

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
